// File: rtl/mux16_rr_scheduler.sv
// Round-robin scheduler for a shared 16:1 bit-select mux: one-hot grant, bounded hold, one-cycle gap.
// Optional MUX16_SCHED_SAMPLE_EN adds a local di[si] sampler (y_q / y_vld).
module mux16_rr_scheduler #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
`ifdef MUX16_SCHED_SAMPLE_EN
  input  logic [15:0] di,
  output logic        y_q,
  output logic        y_vld,
`endif
  output logic [3:0]  si,
  output logic [15:0] gnt,
  output logic        busy,
  output logic        ovf,
  output logic [1:0]  state_dbg
);

  // Handshake: req[i] is a level request. gnt[i] is the acknowledgement and stays
  // high while req[i] stays high, up to MAX_HOLD cycles. Dropping req[i] ends the
  // grant on the next edge. Every grant is followed by one GAP and one IDLE cycle.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

  state_t      state_q, state_d;
  logic [3:0]  si_q, si_d;
  logic [15:0] gnt_q, gnt_d;
  logic        busy_q, busy_d;
  logic        ovf_q, ovf_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  last_q, last_d;

  logic        found;
  logic [3:0]  pick_idx;
  logic [3:0]  cand;

  // Search starts one past the last winner; offset 16 wraps back to last itself.
  always_comb begin
    found    = 1'b0;
    pick_idx = 4'd0;
    cand     = 4'd0;
    for (int k = 0; k < 16; k++) begin
      cand = last_q + 4'(k + 1);
      if (!found && req[cand]) begin
        found    = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    si_d    = si_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    ovf_d   = 1'b0;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          si_d    = pick_idx;
          gnt_d   = 16'(1) << pick_idx;
          busy_d  = 1'b1;
          cnt_d   = 4'd1;
          last_d  = pick_idx;
        end
      end
      GRANT: begin
        if (!req[si_q]) begin
          state_d = GAP;
          gnt_d   = 16'h0000;
          busy_d  = 1'b0;
        end else if (cnt_q == MAX_HOLD_C) begin
          state_d = GAP;
          gnt_d   = 16'h0000;
          busy_d  = 1'b0;
          ovf_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 16'h0000;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      si_q    <= 4'd0;
      gnt_q   <= 16'h0000;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= 4'd0;
      last_q  <= 4'd15;
    end else begin
      state_q <= state_d;
      si_q    <= si_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign si        = si_q;
  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign ovf       = ovf_q;
  assign state_dbg = state_q;

`ifdef MUX16_SCHED_SAMPLE_EN
  logic y_d;
  logic y_vld_q, y_vld_d;

  // si_q is stable for the whole grant, so di[si_q] matches the external mux output.
  always_comb begin
    y_d     = y_q;
    y_vld_d = 1'b0;
    if (state_q == GRANT) begin
      y_d     = di[si_q];
      y_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q     <= 1'b0;
      y_vld_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      y_vld_q <= y_vld_d;
    end
  end

  assign y_vld = y_vld_q;
`endif

endmodule

// File: tb/tb_mux16_rr_scheduler.sv
// Bench for mux16_rr_scheduler (MAX_HOLD=4): vector table, reset/round-robin sequences, expected-value queue.
module tb_mux16_rr_scheduler;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic [3:0]  si;
  logic [15:0] gnt;
  logic        busy;
  logic        ovf;
  logic [1:0]  state_dbg;
`ifdef MUX16_SCHED_SAMPLE_EN
  logic [15:0] di;
  logic        y_q;
  logic        y_vld;
`endif

  int checks;
  int failures;

  logic [21:0] exp_q[$];

  typedef struct {
    logic [15:0] req;
    logic [3:0]  si;
    logic [15:0] gnt;
    logic        busy;
    logic        ovf;
  } vec_t;

  vec_t tbl[29];

  mux16_rr_scheduler #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
`ifdef MUX16_SCHED_SAMPLE_EN
    .di        (di),
    .y_q       (y_q),
    .y_vld     (y_vld),
`endif
    .si        (si),
    .gnt       (gnt),
    .busy      (busy),
    .ovf       (ovf),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [21:0] pk(input logic [3:0] s, input logic [15:0] g,
                                     input logic b, input logic o);
    return {s, g, b, o};
  endfunction

  task automatic check_outputs(input string nm);
    logic [21:0] e;
    logic [21:0] got;
    got = {si, gnt, busy, ovf};
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: expected queue empty, got si=%0d gnt=%h", nm, si, gnt);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL %s: got si=%0d gnt=%h busy=%b ovf=%b, expected si=%0d gnt=%h busy=%b ovf=%b",
                 nm, got[21:18], got[17:2], got[1], got[0], e[21:18], e[17:2], e[1], e[0]);
      end
    end
    checks++;
    if (((gnt & (gnt - 16'd1)) != 16'd0) || (busy !== (|gnt))) begin
      failures++;
      $display("FAIL %s_invariant: got gnt=%h busy=%b, expected one-hot/zero gnt with busy=|gnt",
               nm, gnt, busy);
    end
  endtask

  // driver: called at a negedge; drives req, pushes expectation, checks #1 after posedge
  task automatic step(input logic [15:0] r, input logic [21:0] e, input string nm);
    req = r;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_outputs(nm);
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] s;
    int g;
    int p;

    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    req      = 16'h0000;
`ifdef MUX16_SCHED_SAMPLE_EN
    di       = 16'h0000;
`endif

    tbl[0]  = '{16'h0020, 4'd5,  16'h0020, 1'b1, 1'b0};
    tbl[1]  = '{16'h0020, 4'd5,  16'h0020, 1'b1, 1'b0};
    tbl[2]  = '{16'h0000, 4'd5,  16'h0000, 1'b0, 1'b0};
    tbl[3]  = '{16'h0000, 4'd5,  16'h0000, 1'b0, 1'b0};
    tbl[4]  = '{16'h0001, 4'd0,  16'h0001, 1'b1, 1'b0};
    tbl[5]  = '{16'h0001, 4'd0,  16'h0001, 1'b1, 1'b0};
    tbl[6]  = '{16'h0001, 4'd0,  16'h0001, 1'b1, 1'b0};
    tbl[7]  = '{16'h0001, 4'd0,  16'h0001, 1'b1, 1'b0};
    tbl[8]  = '{16'h0001, 4'd0,  16'h0000, 1'b0, 1'b1};
    tbl[9]  = '{16'h0001, 4'd0,  16'h0000, 1'b0, 1'b0};
    tbl[10] = '{16'h0001, 4'd0,  16'h0001, 1'b1, 1'b0};
    tbl[11] = '{16'h0001, 4'd0,  16'h0001, 1'b1, 1'b0};
    tbl[12] = '{16'h0001, 4'd0,  16'h0001, 1'b1, 1'b0};
    tbl[13] = '{16'h0001, 4'd0,  16'h0001, 1'b1, 1'b0};
    tbl[14] = '{16'h0001, 4'd0,  16'h0000, 1'b0, 1'b1};
    tbl[15] = '{16'h0000, 4'd0,  16'h0000, 1'b0, 1'b0};
    tbl[16] = '{16'h4000, 4'd14, 16'h4000, 1'b1, 1'b0};
    tbl[17] = '{16'h0000, 4'd14, 16'h0000, 1'b0, 1'b0};
    tbl[18] = '{16'h4001, 4'd14, 16'h0000, 1'b0, 1'b0};
    tbl[19] = '{16'h4001, 4'd0,  16'h0001, 1'b1, 1'b0};
    tbl[20] = '{16'h4000, 4'd0,  16'h0000, 1'b0, 1'b0};
    tbl[21] = '{16'h4001, 4'd0,  16'h0000, 1'b0, 1'b0};
    tbl[22] = '{16'h4001, 4'd14, 16'h4000, 1'b1, 1'b0};
    tbl[23] = '{16'h0000, 4'd14, 16'h0000, 1'b0, 1'b0};
    tbl[24] = '{16'h0000, 4'd14, 16'h0000, 1'b0, 1'b0};
    tbl[25] = '{16'h0008, 4'd3,  16'h0008, 1'b1, 1'b0};
    tbl[26] = '{16'hFFF8, 4'd3,  16'h0008, 1'b1, 1'b0};
    tbl[27] = '{16'h0000, 4'd3,  16'h0000, 1'b0, 1'b0};
    tbl[28] = '{16'h0000, 4'd3,  16'h0000, 1'b0, 1'b0};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(pk(4'd0, 16'h0000, 1'b0, 1'b0));
    check_outputs("reset_state");
    @(negedge clk);
    rst = 1'b0;

    // short request, hold expiry, wrap-around, ignored req bits during grant
    for (int i = 0; i < 29; i++) begin
      step(tbl[i].req, pk(tbl[i].si, tbl[i].gnt, tbl[i].busy, tbl[i].ovf),
           $sformatf("vec%0d", i));
    end

    // asynchronous reset mid-grant
    step(16'h0008, pk(4'd3, 16'h0008, 1'b1, 1'b0), "pre_rst_grant");
    rst = 1'b1;
    #1;
    exp_q.push_back(pk(4'd0, 16'h0000, 1'b0, 1'b0));
    check_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    step(16'h0008, pk(4'd3, 16'h0008, 1'b1, 1'b0), "post_rst_grant");

    // round-robin with all sources requesting, from a fresh reset
    req = 16'h0000;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 17 * 6; k++) begin
      g = k / 6;
      p = k % 6;
      s = 4'(g % 16);
      if (p < 4)
        step(16'hFFFF, pk(s, 16'(1) << s, 1'b1, 1'b0), $sformatf("rr%0d_p%0d", g, p));
      else if (p == 4)
        step(16'hFFFF, pk(s, 16'h0000, 1'b0, 1'b1), $sformatf("rr%0d_gap", g));
      else
        step(16'hFFFF, pk(s, 16'h0000, 1'b0, 1'b0), $sformatf("rr%0d_idle", g));
    end

`ifdef MUX16_SCHED_SAMPLE_EN
    req = 16'h0000;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    di = 16'h0400;
    step(16'h0400, pk(4'd10, 16'h0400, 1'b1, 1'b0), "smp_grant");
    step(16'h0400, pk(4'd10, 16'h0400, 1'b1, 1'b0), "smp_hold");
    checks++;
    if (y_q !== 1'b1 || y_vld !== 1'b1) begin
      failures++;
      $display("FAIL sample_one: got y_q=%b y_vld=%b, expected y_q=1 y_vld=1", y_q, y_vld);
    end
    di = 16'h0000;
    step(16'h0400, pk(4'd10, 16'h0400, 1'b1, 1'b0), "smp_hold2");
    checks++;
    if (y_q !== 1'b0 || y_vld !== 1'b1) begin
      failures++;
      $display("FAIL sample_zero: got y_q=%b y_vld=%b, expected y_q=0 y_vld=1", y_q, y_vld);
    end
`endif

    // final report
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: got %0d leftover entries, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
